// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the pipelined decode stage.
//   - opcode encodings
//   - instruction field bit positions
//   - per-opcode decode helpers: imm_gen, reads_a, reads_b, b_is_rt, writes_rd
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  // Field LSB positions within the 32-bit instruction word.
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RD_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_LSB = 0;

  // imm_gen works at this width and then masks down to the caller's width,
  // so one function serves any DATA_W up to this bound.
  localparam int IMM_MAX_W = 128;

  function automatic logic [IMM_MAX_W-1:0] imm_gen(input logic [5:0]  opcode,
                                                   input logic [15:0] imm,
                                                   input int          data_w);
    logic [IMM_MAX_W-1:0] sext;
    logic [IMM_MAX_W-1:0] zext;
    logic [IMM_MAX_W-1:0] res;
    sext = {{(IMM_MAX_W-16){imm[15]}}, imm};
    zext = {{(IMM_MAX_W-16){1'b0}}, imm};
    case (opcode)
      OP_LUI:               res = zext << 16;
      OP_ANDI, OP_ORI:      res = zext;
      OP_B, OP_BEQ, OP_BNE: res = sext << 2;
      default:              res = sext;
    endcase
    for (int i = 0; i < IMM_MAX_W; i++) begin
      if (i >= data_w) res[i] = 1'b0;
    end
    return res;
  endfunction

  function automatic logic is_known(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_B,
      OP_BEQ, OP_BNE, OP_LB, OP_SB, OP_LW, OP_SW: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // Unknown opcodes are NOPs, so they read nothing.
  function automatic logic reads_a(input logic [5:0] opcode);
    return is_known(opcode) && (opcode != OP_LI) && (opcode != OP_LUI) && (opcode != OP_B);
  endfunction

  function automatic logic reads_b(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SW: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Port B address: rt for R-type, rd for branches and stores.
  function automatic logic b_is_rt(input logic [5:0] opcode);
    return opcode == OP_RTYPE;
  endfunction

  function automatic logic writes_rd(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_LB, OP_LW: return 1'b1;
      default:                                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_pipe_regfile.sv
// regfile: NREGS x DATA_W register file.
//   clk, reset           : clock, asynchronous active-high reset (clears all regs)
//   we, waddr, wdata     : write port, takes effect at the rising edge
//   raddr_a / rdata_a    : combinational read port A
//   raddr_b / rdata_b    : combinational read port B
// r0 always reads 0 and ignores writes. A read of the address being written
// this cycle returns wdata (write-back bypass).
module regfile #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_reg [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_reg[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) rdata_a = (we && (waddr == raddr_a)) ? wdata : mem_reg[raddr_a];
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) rdata_b = (we && (waddr == raddr_b)) ? wdata : mem_reg[raddr_b];
  end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: pipelined decode stage between fetch and execute.
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid/in_ready/instr : instruction handshake from fetch
//   wb_en/wb_addr/wb_sel    : register write-back (wb_sel 1 = mem_out, 0 = alu_out)
//   alu_out, mem_out        : write-back data sources
//   flush                   : kill the instruction held in ID/EX
//   out_valid/out_ready     : ID/EX handshake to execute
//   out_opcode/out_rd/out_wr/out_immed/out_rfa/out_rfb : decoded operands
// A busy bit per register tracks in-flight destinations; issue stalls on
// RAW/WAW against busy registers unless that register is being written back
// in the same cycle, in which case the bypassed value is captured.
module decode_pipe
  import decode_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_addr,
  input  logic              wb_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [RW-1:0]     out_rd,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_immed,
  output logic [DATA_W-1:0] out_rfa,
  output logic [DATA_W-1:0] out_rfb
);

  logic [5:0]        opcode;
  logic [RW-1:0]     rs, rd, rt;
  logic [15:0]       imm;
  logic              dec_reads_a, dec_reads_b, dec_b_is_rt, dec_writes;
  logic [RW-1:0]     ra_addr, rb_addr;
  logic [DATA_W-1:0] wb_data, rfa_data, rfb_data, imm_ext;
  logic [NREGS-1:0]  busy_reg, busy_next, pending;
  logic              hazard, issue;

  assign opcode = instr[OPC_LSB +: 6];
  assign rs     = instr[RS_LSB +: RW];
  assign rd     = instr[RD_LSB +: RW];
  assign rt     = instr[RT_LSB +: RW];
  assign imm    = instr[IMM_LSB +: 16];

  assign dec_reads_a = reads_a(opcode);
  assign dec_reads_b = reads_b(opcode);
  assign dec_b_is_rt = b_is_rt(opcode);
  assign dec_writes  = writes_rd(opcode);
  assign imm_ext     = DATA_W'(imm_gen(opcode, imm, DATA_W));

  // Ports that read nothing are pointed at r0, which yields 0.
  assign ra_addr = dec_reads_a ? rs : '0;
  assign rb_addr = dec_reads_b ? (dec_b_is_rt ? rt : rd) : '0;

  assign wb_data = wb_sel ? mem_out : alu_out;

  regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ra_addr),
    .rdata_a (rfa_data),
    .raddr_b (rb_addr),
    .rdata_b (rfb_data)
  );

  // pending: busy and not retiring this cycle, i.e. a real hazard source.
  // busy_next: set on issue beats clear from write-back or flush.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    assign pending[gi] = busy_reg[gi] && !(wb_en && (wb_addr == RW'(gi)));
    if (gi == 0) begin : g_r0
      assign busy_next[gi] = 1'b0;
    end else begin : g_rn
      logic set_hit, clr_hit;
      assign set_hit = issue && dec_writes && (rd == RW'(gi));
      assign clr_hit = (wb_en && (wb_addr == RW'(gi))) ||
                       (flush && out_valid && out_wr && (out_rd == RW'(gi)));
      assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
    end
  end

  assign hazard = (dec_reads_a && pending[ra_addr]) ||
                  (dec_reads_b && pending[rb_addr]) ||
                  (dec_writes  && pending[rd]);

  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign issue    = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  // ID/EX register. Issue is impossible while the held entry is stalled,
  // so the payload only changes when it is free or being consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_wr     <= 1'b0;
      out_immed  <= '0;
      out_rfa    <= '0;
      out_rfb    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_opcode <= opcode;
      out_rd     <= rd;
      out_wr     <= dec_writes;
      out_immed  <= imm_ext;
      out_rfa    <= rfa_data;
      out_rfb    <= rfb_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Pipelined successor to the single-cycle decode stage. It holds the register file, generates the immediate, and derives the read-port-B select from the opcode instead of an external `rf_b_sel`. It tracks in-flight destination registers in a busy scoreboard, stalls on RAW/WAW hazards, bypasses same-cycle write-back, and hands the decoded operands to execute through a valid/ready ID/EX register. It sits between the fetch stage and the execute stage.

## Interface
- `DATA_W`, 32: operand/register width, ≥32; immediates extend to DATA_W.
- `NREGS`, 32: register count, power of 2, 2..32; index width `RW = $clog2(NREGS)`, upper instruction field bits ignored.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: `instr` valid from fetch.
- `in_ready` out 1: decode accepts `instr` this cycle.
- `instr` in 32: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], imm[15:0].
- `wb_en` in 1: register write-back strobe.
- `wb_addr` in RW: write-back destination.
- `wb_sel` in 1: 0 = `alu_out`, 1 = `mem_out`.
- `alu_out`, `mem_out` in DATA_W: write-back sources.
- `flush` in 1: kill the instruction held in the ID/EX register.
- `out_valid` out 1: ID/EX register holds a live instruction.
- `out_ready` in 1: execute consumes it.
- `out_opcode` out 6; `out_rd` out RW; `out_wr` out 1 (instruction writes rd).
- `out_immed`, `out_rfa`, `out_rfb` out DATA_W.

## Operation
- Opcodes: R-type 100000; li 111000; lui 111001; addi 110000; andi 110010; ori 110011; b 111111; beq 000000; bne 000001; lb 000011; sb 000111; lw 001111; sw 011111. Any other opcode decodes as a NOP: no reads, no write, still issues.
- Immediate:
  - lui: imm<<16, zero-filled.
  - andi/ori: zero-extended.
  - b/beq/bne: sign-extended, then <<2.
  - all others: sign-extended.
- Port A reads rs for all opcodes except li, lui, b.
- Port B reads rt for R-type. It reads rd for beq, bne, sb, sw. It reads nothing otherwise, and `out_rfb` = 0.
- Writes rd: R-type, li, lui, addi, andi, ori, lb, lw.
- r0 reads 0, ignores writes, and is never busy.
- Scoreboard: one busy bit per register.
  - Set on issue of an instruction with `out_wr` and rd≠0.
  - Cleared on `wb_en` to that address.
  - If set and clear hit the same bit in the same cycle, set wins.
- Hazard when either of the following holds:
  - a read source is busy and is not being written back this cycle (RAW);
  - the destination is busy and is not being written back this cycle (WAW).
- Bypass: a read whose address equals `wb_addr` while `wb_en` is high returns the write-back data.
- `in_ready = !hazard && (!out_valid || out_ready) && !flush`. Issue occurs when `in_valid && in_ready`.
- Flush:
  - clears `out_valid`;
  - clears the busy bit of the held instruction's rd if `out_valid && out_wr`;
  - blocks issue that cycle;
  - write-back still proceeds.
- Held outputs stay stable while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous): all registers 0, all busy bits 0, `out_valid` 0, all `out_*` 0. `in_ready` follows its equation.
- Register-file write takes effect at the rising edge with `wb_en`. Reads are combinational with write-back bypass.
- Latency: `instr` accepted at edge N appears on `out_*` with `out_valid` after edge N; one cycle.
- Throughput: one instruction per cycle with no hazards and `out_ready` = 1.
- A hazard stalls until the write-back cycle itself. `in_ready` rises in that cycle and the bypassed value is captured.
- Reset mid-stall clears the scoreboard. Fetch replays the instruction.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams;
  - field bit positions;
  - functions `imm_gen(opcode, imm, DATA_W)`, `reads_a`, `reads_b`, `b_is_rt`, `writes_rd`.
- Sub-module `regfile` holds NREGS×DATA_W storage with two combinational read ports, one write port, internal write-back bypass, r0 = 0, and asynchronous reset.
- `decode_pipe` holds the scoreboard, hazard logic, and ID/EX register.

## Test plan
- Reset, then `instr` 0xC0010005 (addi r1,r0,5) → next cycle: `out_valid` 1, `out_immed` 5, `out_rfa` 0, `out_rd` 1, `out_wr` 1, busy[1] 1.
- `instr` 0xE4021234 (lui) → `out_immed` 0x12340000. `instr` 0xFC00FFFF (b) → `out_immed` 0xFFFFFFFC. andi with imm 0x8000 → `out_immed` 0x00008000.
- After addi r1: R-type rs=1, rt=2, rd=3 → `in_ready` 0. Then `wb_en`, `wb_addr` 1, `wb_sel` 0, `alu_out` 12 → `in_ready` 1 that cycle, `out_rfa` 12 next cycle, busy[1] 0.
- `out_ready` 0 for 3 cycles while `in_valid` 1 → `in_ready` 0, outputs stable. Release → one issue per cycle resumes.
- `flush` with addi r4 held → `out_valid` 0, busy[4] 0. A following instruction reading r4 issues without stall.
- Write r0 with `mem_out` 23 → r0 still reads 0. Assert `reset` mid-stall → `out_valid` 0, all busy bits clear immediately.
